// File: rtl/id_stage.sv
// Decode stage: latches the fetched instruction, resolves operands with
// EX/MEM/WB forwarding, stalls on unavailable results and resolves branches.
module id_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_to_id_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_allowin,
  output logic        br_taken,
  output logic [31:0] br_target,
  input  logic        ex_allowin,
  output logic        id_to_ex_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_src1,
  output logic [31:0] id_src2,
  output logic [4:0]  id_dest,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic [4:0]  ex_fwd_dest,
  input  logic        ex_fwd_busy,
  input  logic [31:0] ex_fwd_data,
  input  logic [4:0]  mem_fwd_dest,
  input  logic [31:0] mem_fwd_data,
  input  logic [4:0]  wb_fwd_dest,
  input  logic [31:0] wb_fwd_data
);

  logic               id_valid;
  logic               id_ready_go;
  logic               is_b, is_bl, is_jirl, is_beq, is_bne, is_st, is_3r, is_lu12i;
  logic               uses1, uses2;
  logic               cond;
  logic signed [31:0] off26, off16;

  // Youngest producer wins; r0 always reads as zero.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  a,
    input logic [4:0]  ex_d,
    input logic [31:0] ex_v,
    input logic [4:0]  mem_d,
    input logic [31:0] mem_v,
    input logic [4:0]  wb_d,
    input logic [31:0] wb_v,
    input logic [31:0] rf_v
  );
    if (a == 5'd0)  return 32'd0;
    if (a == ex_d)  return ex_v;
    if (a == mem_d) return mem_v;
    if (a == wb_d)  return wb_v;
    return rf_v;
  endfunction

  function automatic logic src_wait(
    input logic [4:0] a,
    input logic       used,
    input logic [4:0] ex_d,
    input logic       ex_busy,
    input logic [4:0] mem_d,
    input logic [4:0] wb_d
  );
    if (!used || a == 5'd0) return 1'b0;
    if (FWD_EN) return (a == ex_d) && ex_busy;
    return (a == ex_d) || (a == mem_d) || (a == wb_d);
  endfunction

  assign is_b     = id_inst[31:26] == 6'b010100;
  assign is_bl    = id_inst[31:26] == 6'b010101;
  assign is_jirl  = id_inst[31:26] == 6'b010011;
  assign is_beq   = id_inst[31:26] == 6'b010110;
  assign is_bne   = id_inst[31:26] == 6'b010111;
  assign is_st    = id_inst[31:22] == 10'b0010100110;
  assign is_3r    = (id_inst[31:20] == 12'h001) || (id_inst[31:20] == 12'h002);
  assign is_lu12i = id_inst[31:25] == 7'b0001010;

  assign uses1 = ~(is_b | is_bl | is_lu12i);
  assign uses2 = is_beq | is_bne | is_st | is_3r;

  assign rf_raddr1 = id_inst[9:5];
  assign rf_raddr2 = (is_beq | is_bne | is_st) ? id_inst[4:0] : id_inst[14:10];
  assign id_dest   = is_bl ? 5'd1 :
                     (is_b | is_beq | is_bne | is_st) ? 5'd0 : id_inst[4:0];

  assign id_src1 = fwd_sel(rf_raddr1, ex_fwd_dest, ex_fwd_data, mem_fwd_dest, mem_fwd_data,
                           wb_fwd_dest, wb_fwd_data, rf_rdata1);
  assign id_src2 = fwd_sel(rf_raddr2, ex_fwd_dest, ex_fwd_data, mem_fwd_dest, mem_fwd_data,
                           wb_fwd_dest, wb_fwd_data, rf_rdata2);

  assign id_ready_go = ~(src_wait(rf_raddr1, uses1, ex_fwd_dest, ex_fwd_busy, mem_fwd_dest, wb_fwd_dest) |
                         src_wait(rf_raddr2, uses2, ex_fwd_dest, ex_fwd_busy, mem_fwd_dest, wb_fwd_dest));

  assign id_allowin     = ~id_valid | (id_ready_go & ex_allowin);
  assign id_to_ex_valid = id_valid & id_ready_go;

  assign off26 = {{4{id_inst[9]}}, id_inst[9:0], id_inst[25:10], 2'b00};
  assign off16 = {{14{id_inst[25]}}, id_inst[25:10], 2'b00};

  always_comb begin
    cond = 1'b0;
    if (is_b | is_bl | is_jirl) cond = 1'b1;
    else if (is_beq)            cond = (id_src1 == id_src2);
    else if (is_bne)            cond = (id_src1 != id_src2);
  end

  always_comb begin
    br_target = id_pc + $unsigned(off16);
    if (is_b | is_bl) br_target = id_pc + $unsigned(off26);
    else if (is_jirl) br_target = id_src1 + $unsigned(off16);
  end

  // Redirect only on the handoff edge, so a stalled branch never loses fetch.
  assign br_taken = id_valid & id_ready_go & ex_allowin & cond;

  // IF -> ID stage register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid <= 1'b0;
      id_pc    <= 32'd0;
      id_inst  <= 32'd0;
    end else if (id_allowin) begin
      id_valid <= if_to_id_valid & ~br_taken;
      id_pc    <= if_pc;
      id_inst  <= if_inst;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random instruction streams, both
// forwarding variants checked every cycle against a spec-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_to_id_valid;
  logic [31:0] if_inst, if_pc;
  logic        ex_allowin;
  logic [4:0]  ex_fwd_dest, mem_fwd_dest, wb_fwd_dest;
  logic        ex_fwd_busy;
  logic [31:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic [31:0] rf [32];

  logic [1:0]  allow_o, brt_o, v_o;
  logic [31:0] tgt_o [2], pc_o [2], inst_o [2], s1_o [2], s2_o [2], rd1 [2], rd2 [2];
  logic [4:0]  dest_o [2], ra1_o [2], ra2_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd1[0] = rf[ra1_o[0]];
  assign rd2[0] = rf[ra2_o[0]];
  assign rd1[1] = rf[ra1_o[1]];
  assign rd2[1] = rf[ra2_o[1]];

  id_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .if_to_id_valid(if_to_id_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_allowin(allow_o[0]), .br_taken(brt_o[0]), .br_target(tgt_o[0]), .ex_allowin(ex_allowin),
    .id_to_ex_valid(v_o[0]), .id_pc(pc_o[0]), .id_inst(inst_o[0]), .id_src1(s1_o[0]), .id_src2(s2_o[0]),
    .id_dest(dest_o[0]), .rf_raddr1(ra1_o[0]), .rf_raddr2(ra2_o[0]), .rf_rdata1(rd1[0]), .rf_rdata2(rd2[0]),
    .ex_fwd_dest(ex_fwd_dest), .ex_fwd_busy(ex_fwd_busy), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_data(wb_fwd_data));

  id_stage #(.FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .resetn(resetn), .if_to_id_valid(if_to_id_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_allowin(allow_o[1]), .br_taken(brt_o[1]), .br_target(tgt_o[1]), .ex_allowin(ex_allowin),
    .id_to_ex_valid(v_o[1]), .id_pc(pc_o[1]), .id_inst(inst_o[1]), .id_src1(s1_o[1]), .id_src2(s2_o[1]),
    .id_dest(dest_o[1]), .rf_raddr1(ra1_o[1]), .rf_raddr2(ra2_o[1]), .rf_rdata1(rd1[1]), .rf_rdata2(rd2[1]),
    .ex_fwd_dest(ex_fwd_dest), .ex_fwd_busy(ex_fwd_busy), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_data(wb_fwd_data));

  localparam logic [31:0] BEQ45   = 32'h5800_1085; // beq r4,r5,+4 words
  localparam logic [31:0] BNE45   = 32'h5C00_1085;
  localparam logic [31:0] JIRL14  = 32'h4FFF_FC81; // jirl r1,r4,-1 word
  localparam logic [31:0] ADD645  = 32'h0010_1486; // add.w r6,r4,r5
  localparam logic [31:0] ADD605  = 32'h0010_1406; // add.w r6,r0,r5
  localparam logic [31:0] B8      = 32'h5000_2000; // b +8 words

  typedef struct packed {
    logic        ready;
    logic        cond;
    logic [31:0] tgt;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
  } exp_t;

  // Reference state of each ID instance: 0 = forwarding, 1 = no forwarding.
  logic        m_valid [2];
  logic [31:0] m_pc [2], m_inst [2];
  logic        e_allow [2], e_br [2];

  function automatic logic [31:0] operand(input logic [4:0] a);
    if (a == 5'd0)           return 32'd0;
    if (a == ex_fwd_dest)    return ex_fwd_data;
    if (a == mem_fwd_dest)   return mem_fwd_data;
    if (a == wb_fwd_dest)    return wb_fwd_data;
    return rf[a];
  endfunction

  function automatic logic must_wait(input logic [4:0] a, input int idx);
    if (a == 5'd0) return 1'b0;
    if (idx == 0)  return (a == ex_fwd_dest) && ex_fwd_busy;
    return (a == ex_fwd_dest) || (a == mem_fwd_dest) || (a == wb_fwd_dest);
  endfunction

  function automatic exp_t model(input int idx);
    exp_t e;
    logic [31:0] in = m_inst[idx];
    logic [31:0] pc = m_pc[idx];
    logic b    = in[31:26] == 6'b010100;
    logic bl   = in[31:26] == 6'b010101;
    logic jirl = in[31:26] == 6'b010011;
    logic beq  = in[31:26] == 6'b010110;
    logic bne  = in[31:26] == 6'b010111;
    logic st   = in[31:22] == 10'b0010100110;
    logic r3   = (in[31:20] == 12'h001) || (in[31:20] == 12'h002);
    logic lu   = in[31:25] == 7'b0001010;
    logic signed [25:0] o26 = {in[9:0], in[25:10]};
    logic signed [15:0] o16 = in[25:10];
    e.ra1  = in[9:5];
    e.ra2  = (beq || bne || st) ? in[4:0] : in[14:10];
    e.s1   = operand(e.ra1);
    e.s2   = operand(e.ra2);
    e.ready = !(((!(b || bl || lu)) && must_wait(e.ra1, idx)) ||
                ((beq || bne || st || r3) && must_wait(e.ra2, idx)));
    e.dest = bl ? 5'd1 : (b || bl || beq || bne || st) ? 5'd0 : in[4:0];
    e.cond = b || bl || jirl || (beq && e.s1 == e.s2) || (bne && e.s1 != e.s2);
    if (b || bl)   e.tgt = pc + 32'(o26) * 4;
    else if (jirl) e.tgt = e.s1 + 32'(o16) * 4;
    else           e.tgt = pc + 32'(o16) * 4;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_inst(input int idx);
    exp_t e = model(idx);
    logic xv = m_valid[idx] && e.ready;
    logic xa = !m_valid[idx] || (e.ready && ex_allowin);
    logic xb = m_valid[idx] && e.ready && ex_allowin && e.cond;
    chk($sformatf("id_to_ex_valid[%0d]", idx), 32'(v_o[idx]), 32'(xv));
    chk($sformatf("id_allowin[%0d]", idx), 32'(allow_o[idx]), 32'(xa));
    chk($sformatf("br_taken[%0d]", idx), 32'(brt_o[idx]), 32'(xb));
    chk($sformatf("id_pc[%0d]", idx), pc_o[idx], m_pc[idx]);
    chk($sformatf("id_inst[%0d]", idx), inst_o[idx], m_inst[idx]);
    chk($sformatf("rf_raddr1[%0d]", idx), 32'(ra1_o[idx]), 32'(e.ra1));
    chk($sformatf("rf_raddr2[%0d]", idx), 32'(ra2_o[idx]), 32'(e.ra2));
    if (m_valid[idx]) chk($sformatf("id_dest[%0d]", idx), 32'(dest_o[idx]), 32'(e.dest));
    if (xv) begin
      chk($sformatf("id_src1[%0d]", idx), s1_o[idx], e.s1);
      chk($sformatf("id_src2[%0d]", idx), s2_o[idx], e.s2);
    end
    if (xb) chk($sformatf("br_target[%0d]", idx), tgt_o[idx], e.tgt);
    e_allow[idx] = xa;
    e_br[idx]    = xb;
  endtask

  task automatic settle();
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (e_allow[i]) begin
        m_valid[i] = if_to_id_valid && !e_br[i];
        m_pc[i]    = if_pc;
        m_inst[i]  = if_inst;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic clear_fwd();
    ex_fwd_dest = 5'd0; mem_fwd_dest = 5'd0; wb_fwd_dest = 5'd0; ex_fwd_busy = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    r[14:10] = 5'($urandom_range(0, 7));
    r[9:5]   = 5'($urandom_range(0, 7));
    r[4:0]   = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: r[31:26] = 6'b010100;
      1: r[31:26] = 6'b010101;
      2: r[31:26] = 6'b010011;
      3: r[31:26] = 6'b010110;
      4: r[31:26] = 6'b010111;
      5: r[31:22] = 10'b0010100110;
      6: r[31:20] = $urandom_range(0, 1) ? 12'h001 : 12'h002;
      7: r[31:25] = 7'b0001010;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    resetn = 1'b0;
    if_to_id_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0; ex_allowin = 1'b1;
    ex_fwd_data = 32'd0; mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
    clear_fwd();
    for (int i = 0; i < 32; i++) rf[i] = 32'($urandom_range(0, 3));
    rf[0] = 32'hdead_beef;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = 32'd0; m_inst[i] = 32'd0;
    end
    @(negedge clk);
    settle();
    @(negedge clk);
    resetn = 1'b1;

    // beq taken and wrong-path squash
    rf[4] = 32'd7; rf[5] = 32'd7;
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_0010; if_inst = BEQ45;
    step();
    if_pc = 32'h1c00_0014; if_inst = ADD645;
    settle();
    chk("beq_taken", 32'(brt_o[0]), 32'd1);
    chk("beq_target", tgt_o[0], 32'h1c00_0020);
    advance();
    if_to_id_valid = 1'b0;
    settle();
    chk("squash_valid", 32'(v_o[0]), 32'd0);
    chk("squash_pc", pc_o[0], 32'h1c00_0014);
    chk("squash_no_br", 32'(brt_o[0]), 32'd0);
    advance();

    // bne not taken, then jirl
    rf[4] = 32'h1c00_0100; rf[5] = 32'h1c00_0100;
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_0020; if_inst = BNE45;
    step();
    if_pc = 32'h1c00_0024; if_inst = JIRL14;
    settle();
    chk("bne_not_taken", 32'(brt_o[0]), 32'd0);
    advance();
    if_to_id_valid = 1'b0;
    settle();
    chk("jirl_taken", 32'(brt_o[0]), 32'd1);
    chk("jirl_target", tgt_o[0], 32'h1c00_00fc);
    advance();

    // load-use stall
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_0030; if_inst = ADD645;
    step();
    if_pc = 32'h1c00_0034;
    ex_fwd_dest = 5'd4; ex_fwd_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("loaduse_valid", 32'(v_o[0]), 32'd0);
      chk("loaduse_allowin", 32'(allow_o[0]), 32'd0);
      advance();
    end
    ex_fwd_busy = 1'b0; ex_fwd_data = 32'h55;
    settle();
    chk("loaduse_src1", s1_o[0], 32'h55);
    chk("loaduse_handoff", 32'(v_o[0]), 32'd1);
    advance();
    if_to_id_valid = 1'b0; clear_fwd();
    step(); step();

    // forwarding priority, then r0 never hazards
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_0040; if_inst = ADD645;
    step();
    if_pc = 32'h1c00_0044; if_inst = ADD605;
    ex_fwd_dest = 5'd5; mem_fwd_dest = 5'd5; wb_fwd_dest = 5'd5;
    ex_fwd_data = 32'd1; mem_fwd_data = 32'd2; wb_fwd_data = 32'd3;
    settle();
    chk("prio_src2", s2_o[0], 32'd1);
    chk("nofwd_stall_ex", 32'(v_o[1]), 32'd0);
    advance();
    if_to_id_valid = 1'b0; clear_fwd(); ex_fwd_busy = 1'b1;
    settle();
    chk("r0_src1", s1_o[0], 32'd0);
    chk("r0_no_stall", 32'(v_o[0]), 32'd1);
    advance();
    clear_fwd();
    step(); step();

    // backpressure on a taken b
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_0080; if_inst = B8;
    step();
    ex_allowin = 1'b0; if_pc = 32'h1c00_0084; if_inst = ADD645;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_no_br", 32'(brt_o[0]), 32'd0);
      chk("bp_hold_pc", pc_o[0], 32'h1c00_0080);
      advance();
    end
    ex_allowin = 1'b1;
    settle();
    chk("bp_br_pulse", 32'(brt_o[0]), 32'd1);
    chk("bp_handoff", 32'(v_o[0]), 32'd1);
    chk("bp_target", tgt_o[0], 32'h1c00_00a0);
    advance();
    if_to_id_valid = 1'b0;
    settle();
    chk("bp_squash", 32'(v_o[0]), 32'd0);
    advance();

    // no-forwarding variant stalls on a MEM match
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_0090; if_inst = ADD645;
    step();
    if_to_id_valid = 1'b0; mem_fwd_dest = 5'd5;
    settle();
    chk("mem_match_fwd_go", 32'(v_o[0]), 32'd1);
    chk("mem_match_nofwd_stall", 32'(v_o[1]), 32'd0);
    advance();
    mem_fwd_dest = 5'd0;
    settle();
    chk("mem_clear_nofwd_go", 32'(v_o[1]), 32'd1);
    advance();

    // reset mid-stream with a valid instruction held by backpressure
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_00a0; if_inst = B8; ex_allowin = 1'b0;
    step();
    #1;
    chk("pre_reset_valid", 32'(v_o[0]), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", 32'(v_o[0]), 32'd0);
    chk("async_reset_br", 32'(brt_o[0]), 32'd0);
    chk("async_reset_allowin", 32'(allow_o[0]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = 32'd0; m_inst[i] = 32'd0;
    end
    @(negedge clk);
    resetn = 1'b1; ex_allowin = 1'b1;
    if_to_id_valid = 1'b1; if_pc = 32'h1c00_00c0; if_inst = ADD645;
    step();
    if_to_id_valid = 1'b0;
    settle();
    chk("post_reset_accept", pc_o[0], 32'h1c00_00c0);
    chk("post_reset_valid", 32'(v_o[0]), 32'd1);
    advance();

    // random streams
    for (int n = 0; n < 500; n++) begin
      if_to_id_valid = $urandom_range(0, 9) < 8;
      if_pc          = $urandom & ~32'h3;
      if_inst        = rand_inst();
      ex_allowin     = $urandom_range(0, 3) != 0;
      ex_fwd_dest    = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 7));
      mem_fwd_dest   = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 7));
      wb_fwd_dest    = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 7));
      ex_fwd_busy    = $urandom_range(0, 3) == 0;
      ex_fwd_data    = 32'($urandom_range(0, 3));
      mem_fwd_data   = 32'($urandom_range(0, 3));
      wb_fwd_data    = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = 32'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
